vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning idle cycles in COLLECT before auto-refund (used only with VEND_TIMEOUT_EN).
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; one clock, asynchronous and active-low.
REQ-004 The block SHALL have port coin_valid  input  1  one-cycle strobe: coin inserted.
REQ-005 The block SHALL have port coin_value  input  4  coin value; sampled when coin_valid=1.
REQ-006 The block SHALL have port sel_valid  input  1  one-cycle strobe: product selected.
REQ-007 The block SHALL have port sel_code  input  2  product code; sampled when sel_valid=1.
REQ-008 The block SHALL have port sel_count  input  3  quantity; sampled when sel_valid=1.
REQ-009 The block SHALL have port cancel  input  1  one-cycle strobe: refund request.
REQ-010 The block SHALL have port dp_code  output  2  code to pricing datapath.
REQ-011 The block SHALL have port dp_count  output  3  count to pricing datapath.
REQ-012 The block SHALL have port dp_money  output  4  credit to pricing datapath.
REQ-013 The block SHALL have port dp_posibility  input  1  datapath: purchase affordable (combinational from dp_*).
REQ-014 The block SHALL have port dp_remaining  input  4  datapath: change after purchase.
REQ-015 The block SHALL have port dispense  output  1  one-cycle pulse: vend dispense_code.
REQ-016 The block SHALL have port dispense_code  output  2  product code of the vend; held until next vend.
REQ-017 The block SHALL have port change_valid  output  1  one-cycle pulse: return change_amount.
REQ-018 The block SHALL have port change_amount  output  4  change value; valid when change_valid=1.
REQ-019 The block SHALL have port coin_reject  output  1  one-cycle pulse: coin returned unaccepted.
REQ-020 The block SHALL have port insufficient  output  1  one-cycle pulse: selection refused.
REQ-021 The block SHALL have port credit  output  4  current registered credit.
REQ-022 The block SHALL have port busy  output  1  high in CHECK, DISPENSE, REFUND.

Function
REQ-023 The block SHALL implement states IDLE, COLLECT, CHECK, DISPENSE, REFUND; all outputs registered.
REQ-024 IDLE/COLLECT, coin_valid with credit+coin_value <= 15: credit += coin_value, go or stay COLLECT next cycle.
REQ-025 Coin would exceed 15, or coin_value=0, or coin arrives while busy: coin_reject pulses next cycle; credit unchanged.
REQ-026 COLLECT, sel_valid with sel_count=0: insufficient pulses next cycle, remain COLLECT.
REQ-027 COLLECT, sel_valid with sel_count!=0: latch code/count into dp_code/dp_count, go CHECK next cycle; dp_money always equals credit.
REQ-028 CHECK (one cycle) samples dp_posibility: 1 -> DISPENSE; 0 -> insufficient pulse, return COLLECT, credit retained.
REQ-029 DISPENSE (one cycle): dispense=1, change_valid=1, change_amount=dp_remaining as sampled in CHECK; credit:=0; next IDLE.
REQ-030 COLLECT, cancel: REFUND next cycle; REFUND pulses change_valid with change_amount=credit, credit:=0, next IDLE.
REQ-031 Priority in one cycle: cancel > sel_valid > coin_valid; lower-priority coin gets coin_reject, lower selection is dropped.
REQ-032 sel_valid or cancel in IDLE (credit=0) SHALL be ignored with no pulse.
REQ-033 Inputs in CHECK/DISPENSE/REFUND other than coins SHALL be ignored.
REQ-034 change_amount SHALL be 0 whenever change_valid=0.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, credit=0, dp_code=0, dp_count=0, dispense_code=0, all pulse outputs 0, busy=0, timeout counter 0.
REQ-036 Reset mid-transaction SHALL discard credit without a change_valid pulse.

Configuration
REQ-037 With macro VEND_TIMEOUT_EN defined, a counter SHALL clear on each accepted coin or entry to COLLECT and, after TIMEOUT_CYCLES consecutive cycles in COLLECT with no accepted input, force REFUND.
REQ-038 Without VEND_TIMEOUT_EN, no counter SHALL exist and COLLECT SHALL persist indefinitely.

Verification
REQ-039 Coins 5,5 then sel code=1,count=1, stub dp_posibility=1, dp_remaining=3 -> CHECK 1 cycle, then dispense=1, dispense_code=1, change_amount=3, credit=0, IDLE.
REQ-040 Credit 10, coin 8 -> coin_reject pulse, credit stays 10.
REQ-041 Credit 4, sel count=2, stub dp_posibility=0 -> insufficient pulse, back to COLLECT, credit 4.
REQ-042 Credit 7, cancel+sel_valid+coin_valid same cycle -> REFUND, change_amount=7, coin_reject=1, no dispense.
REQ-043 VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8, coin 6 then idle -> change_valid with change_amount=6 after 8 cycles; without macro no refund after 1000 cycles.
REQ-044 rst_n low during CHECK with credit 9 -> all outputs 0 immediately, no change_valid, IDLE after release.

Source files
------------

// File: rtl/vend_controller_if.sv
// -----------------------------------------------------------------------------
// vend_controller_if
// Bundles the vending controller's user-facing strobes, its status outputs and
// the pricing-datapath handshake into one interface.
//   slave  modport : used by vend_controller (samples user inputs and datapath
//                    answers, drives dp_*, pulses and status)
//   master modport : used by whoever drives coins/selections and hosts the
//                    pricing datapath
// Signals:
//   coin_valid/coin_value             coin strobe and value
//   sel_valid/sel_code/sel_count      selection strobe, product code, quantity
//   cancel                            refund request strobe
//   dp_code/dp_count/dp_money         request to the pricing datapath
//   dp_posibility/dp_remaining        datapath answer: affordable, change
//   dispense/dispense_code            vend pulse and product code (code held)
//   change_valid/change_amount        change return pulse and amount
//   coin_reject/insufficient          refusal pulses
//   credit/busy                       status
// -----------------------------------------------------------------------------
interface vend_controller_if;
   logic       coin_valid;
   logic [3:0] coin_value;
   logic       sel_valid;
   logic [1:0] sel_code;
   logic [2:0] sel_count;
   logic       cancel;
   logic [1:0] dp_code;
   logic [2:0] dp_count;
   logic [3:0] dp_money;
   logic       dp_posibility;
   logic [3:0] dp_remaining;
   logic       dispense;
   logic [1:0] dispense_code;
   logic       change_valid;
   logic [3:0] change_amount;
   logic       coin_reject;
   logic       insufficient;
   logic [3:0] credit;
   logic       busy;

   modport slave (
      input  coin_valid, coin_value, sel_valid, sel_code, sel_count, cancel,
      input  dp_posibility, dp_remaining,
      output dp_code, dp_count, dp_money,
      output dispense, dispense_code, change_valid, change_amount,
      output coin_reject, insufficient, credit, busy
   );

   modport master (
      output coin_valid, coin_value, sel_valid, sel_code, sel_count, cancel,
      output dp_posibility, dp_remaining,
      input  dp_code, dp_count, dp_money,
      input  dispense, dispense_code, change_valid, change_amount,
      input  coin_reject, insufficient, credit, busy
   );
endinterface

// File: rtl/vend_controller.sv
// -----------------------------------------------------------------------------
// vend_controller
// Coin-operated vending controller. Collects coins into a 4-bit credit (max 15),
// asks an external pricing datapath whether a selection is affordable, then
// dispenses with change or refunds on cancel. Every output is registered; the
// pulse outputs are high during the state they belong to (DISPENSE/REFUND) or
// for the one cycle after the refused event.
// Ports:
//   clk     rising-edge system clock
//   rst_n   asynchronous active-low reset (discards credit silently)
//   bus     vend_controller_if.slave -- user strobes, datapath handshake,
//           result pulses and status (see vend_controller_if.sv)
// Parameter:
//   TIMEOUT_CYCLES  idle cycles in COLLECT before an automatic refund
// Build option:
//   VEND_TIMEOUT_EN  when defined, adds the COLLECT inactivity counter that
//                    forces a refund; when undefined COLLECT waits forever.
// -----------------------------------------------------------------------------
module vend_controller #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   vend_controller_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COLLECT  = 3'd1,
      ST_CHECK    = 3'd2,
      ST_DISPENSE = 3'd3,
      ST_REFUND   = 3'd4
   } state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   // A coin is usable only if non-zero and the credit stays within 4 bits.
   function automatic logic coin_fits(input logic [3:0] credit_v, input logic [3:0] coin_v);
      logic [4:0] sum_v;
      sum_v     = {1'b0, credit_v} + {1'b0, coin_v};
      coin_fits = (coin_v != 4'd0) && (sum_v <= 5'd15);
   endfunction

   state_t     state_r, state_s;
   logic [3:0] credit_r, credit_s;
   logic [1:0] dp_code_r, dp_code_s;
   logic [2:0] dp_count_r, dp_count_s;
   logic       dispense_r, dispense_s;
   logic [1:0] dispense_code_r, dispense_code_s;
   logic       change_valid_r, change_valid_s;
   logic [3:0] change_amount_r, change_amount_s;
   logic       coin_reject_r, coin_reject_s;
   logic       insufficient_r, insufficient_s;
   logic       busy_r, busy_s;
   logic       coin_accept_s;
   logic       timeout_s;

`ifdef VEND_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMO_W-1:0] tmo_cnt_r;

   assign timeout_s = (state_r == ST_COLLECT) &&
                      (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

   // Inactivity counter: restarts on COLLECT entry or an accepted coin, saturates at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= '0;
      end else if (state_s != ST_COLLECT) begin
         tmo_cnt_r <= '0;
      end else if ((state_r != ST_COLLECT) || coin_accept_s) begin
         tmo_cnt_r <= '0;
      end else if (!timeout_s) begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state and next-output logic; pulse outputs default low every cycle.
   always_comb begin
      state_s         = state_r;
      credit_s        = credit_r;
      dp_code_s       = dp_code_r;
      dp_count_s      = dp_count_r;
      dispense_code_s = dispense_code_r;
      dispense_s      = 1'b0;
      change_valid_s  = 1'b0;
      change_amount_s = 4'd0;
      coin_reject_s   = 1'b0;
      insufficient_s  = 1'b0;
      coin_accept_s   = 1'b0;

      case (state_r)
         ST_IDLE: begin
            // credit is zero here, so selections and cancel have nothing to act on
            if (bus.coin_valid) begin
               if (coin_fits(credit_r, bus.coin_value)) begin
                  credit_s      = credit_r + bus.coin_value;
                  coin_accept_s = 1'b1;
                  state_s       = ST_COLLECT;
               end else begin
                  coin_reject_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_COLLECT: begin
            if (bus.cancel) begin
               // cancel outranks everything; a simultaneous coin is handed back
               state_s         = ST_REFUND;
               change_valid_s  = 1'b1;
               change_amount_s = credit_r;
               credit_s        = 4'd0;
               coin_reject_s   = bus.coin_valid;
            end else if (bus.sel_valid && (bus.sel_count != 3'd0)) begin
               dp_code_s     = bus.sel_code;
               dp_count_s    = bus.sel_count;
               state_s       = ST_CHECK;
               coin_reject_s = bus.coin_valid;
            end else begin
               if (bus.sel_valid) begin
                  insufficient_s = 1'b1;
                  coin_reject_s  = bus.coin_valid;
               end else if (bus.coin_valid) begin
                  if (coin_fits(credit_r, bus.coin_value)) begin
                     credit_s      = credit_r + bus.coin_value;
                     coin_accept_s = 1'b1;
                  end else begin
                     coin_reject_s = 1'b1;
                  end
               end else begin
                  coin_accept_s = 1'b0;
               end
               if (timeout_s && !coin_accept_s) begin
                  state_s         = ST_REFUND;
                  change_valid_s  = 1'b1;
                  change_amount_s = credit_r;
                  credit_s        = 4'd0;
               end else begin
                  state_s = ST_COLLECT;
               end
            end
         end

         ST_CHECK: begin
            coin_reject_s = bus.coin_valid;
            // dp_remaining is captured now, while dp_money still shows the credit
            if (bus.dp_posibility) begin
               state_s         = ST_DISPENSE;
               dispense_s      = 1'b1;
               dispense_code_s = dp_code_r;
               change_valid_s  = 1'b1;
               change_amount_s = bus.dp_remaining;
               credit_s        = 4'd0;
            end else begin
               state_s        = ST_COLLECT;
               insufficient_s = 1'b1;
            end
         end

         ST_DISPENSE: begin
            coin_reject_s = bus.coin_valid;
            state_s       = ST_IDLE;
         end

         ST_REFUND: begin
            coin_reject_s = bus.coin_valid;
            state_s       = ST_IDLE;
         end

         default: begin
            state_s  = ST_IDLE;
            credit_s = 4'd0;
         end
      endcase

      busy_s = (state_s == ST_CHECK) || (state_s == ST_DISPENSE) || (state_s == ST_REFUND);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= ST_IDLE;
         credit_r        <= 4'd0;
         dp_code_r       <= 2'd0;
         dp_count_r      <= 3'd0;
         dispense_r      <= 1'b0;
         dispense_code_r <= 2'd0;
         change_valid_r  <= 1'b0;
         change_amount_r <= 4'd0;
         coin_reject_r   <= 1'b0;
         insufficient_r  <= 1'b0;
         busy_r          <= 1'b0;
      end else begin
         state_r         <= state_s;
         credit_r        <= credit_s;
         dp_code_r       <= dp_code_s;
         dp_count_r      <= dp_count_s;
         dispense_r      <= dispense_s;
         dispense_code_r <= dispense_code_s;
         change_valid_r  <= change_valid_s;
         change_amount_r <= change_amount_s;
         coin_reject_r   <= coin_reject_s;
         insufficient_r  <= insufficient_s;
         busy_r          <= busy_s;
      end
   end

   assign bus.dp_code       = dp_code_r;
   assign bus.dp_count      = dp_count_r;
   assign bus.dp_money      = credit_r;
   assign bus.dispense      = dispense_r;
   assign bus.dispense_code = dispense_code_r;
   assign bus.change_valid  = change_valid_r;
   assign bus.change_amount = change_amount_r;
   assign bus.coin_reject   = coin_reject_r;
   assign bus.insufficient  = insufficient_r;
   assign bus.credit        = credit_r;
   assign bus.busy          = busy_r;

endmodule

// File: tb/tb_vend_controller.sv
// -----------------------------------------------------------------------------
// tb_vend_controller
// Directed bench for vend_controller. Stimulus pushes the expected pulse event
// (dispense / change / coin_reject / insufficient) into a queue; an independent
// monitor pops and compares whenever the DUT raises any pulse output. Credit,
// busy and datapath-request values are checked directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_vend_controller;

   typedef struct packed {
      logic       disp;
      logic [1:0] code;
      logic       cv;
      logic [3:0] amt;
      logic       rej;
      logic       ins;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       stub_pos;
   logic [3:0] stub_rem;
   int         checks = 0;
   int         errors = 0;
   ev_t        exp_q[$];

   vend_controller_if vif();

   assign vif.dp_posibility = stub_pos;
   assign vif.dp_remaining  = stub_rem;

   vend_controller #(.TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif)
   );

   always #5 clk = ~clk;

   function automatic ev_t mk(input logic disp, input logic [1:0] code, input logic cv,
                              input logic [3:0] amt, input logic rej, input logic ins);
      ev_t e;
      e.disp = disp; e.code = code; e.cv = cv; e.amt = amt; e.rej = rej; e.ins = ins;
      return e;
   endfunction

   function automatic string ev_str(input ev_t e);
      return $sformatf("dispense=%0d code=%0d change_valid=%0d amount=%0d reject=%0d insufficient=%0d",
                       e.disp, e.code, e.cv, e.amt, e.rej, e.ins);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      vif.coin_valid = 1'b0;
      vif.coin_value = 4'd0;
      vif.sel_valid  = 1'b0;
      vif.sel_code   = 2'd0;
      vif.sel_count  = 3'd0;
      vif.cancel     = 1'b0;
   endtask

   task automatic coin(input logic [3:0] v);
      vif.coin_valid = 1'b1;
      vif.coin_value = v;
   endtask

   task automatic sel(input logic [1:0] c, input logic [2:0] n);
      vif.sel_valid = 1'b1;
      vif.sel_code  = c;
      vif.sel_count = n;
   endtask

   // Monitor: compares every pulse cycle against the queued expectation.
   always @(negedge clk) begin
      ev_t act_e;
      ev_t exp_e;
      if (rst_n) begin
         checks++;
         if (!vif.change_valid && (vif.change_amount != 4'd0)) begin
            errors++;
            $display("FAIL change_amount_idle: got %0d expected 0", vif.change_amount);
         end
         if (vif.dispense || vif.change_valid || vif.coin_reject || vif.insufficient) begin
            act_e = mk(vif.dispense, vif.dispense ? vif.dispense_code : 2'd0, vif.change_valid,
                       vif.change_amount, vif.coin_reject, vif.insufficient);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: got %s expected no pulse", ev_str(act_e));
            end else begin
               exp_e = exp_q.pop_front();
               if (act_e !== exp_e) begin
                  errors++;
                  $display("FAIL pulse_event: got %s expected %s", ev_str(act_e), ev_str(exp_e));
               end
            end
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      stub_pos = 1'b0;
      stub_rem = 4'd0;
      idle_inputs();
      #2;
      chk("rst_busy", vif.busy, 0);
      chk("rst_credit", vif.credit, 0);
      chk("rst_dp_code", vif.dp_code, 0);
      chk("rst_dp_count", vif.dp_count, 0);
      chk("rst_dispense_code", vif.dispense_code, 0);
      chk("rst_change_valid", vif.change_valid, 0);
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();

      // IDLE ignores selection and cancel without any pulse
      sel(2'd1, 3'd1);
      vif.cancel = 1'b1;
      cycle();
      idle_inputs();
      cycle();
      chk("idle_ignore_busy", vif.busy, 0);
      chk("idle_ignore_credit", vif.credit, 0);

      // 5 + 5, select code 1 x1, affordable with change 3; coin during CHECK refused
      coin(4'd5);
      cycle();
      chk("vend_credit_5", vif.credit, 5);
      cycle();
      chk("vend_credit_10", vif.credit, 10);
      idle_inputs();
      stub_pos = 1'b1;
      stub_rem = 4'd3;
      sel(2'd1, 3'd1);
      cycle();
      idle_inputs();
      chk("vend_check_busy", vif.busy, 1);
      chk("vend_dp_code", vif.dp_code, 1);
      chk("vend_dp_count", vif.dp_count, 1);
      chk("vend_dp_money", vif.dp_money, 10);
      coin(4'd1);
      exp_q.push_back(mk(1'b1, 2'd1, 1'b1, 4'd3, 1'b1, 1'b0));
      cycle();
      idle_inputs();
      chk("vend_dispense_credit", vif.credit, 0);
      chk("vend_dispense_busy", vif.busy, 1);
      cycle();
      chk("vend_idle_busy", vif.busy, 0);
      chk("vend_held_code", vif.dispense_code, 1);

      // overflow and zero-value coins refused, exact 15 accepted, cancel refunds 15
      coin(4'd10);
      cycle();
      chk("ovf_credit_10", vif.credit, 10);
      coin(4'd8);
      exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0));
      cycle();
      chk("ovf_credit_kept", vif.credit, 10);
      coin(4'd0);
      exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0));
      cycle();
      chk("zero_coin_credit", vif.credit, 10);
      coin(4'd5);
      cycle();
      chk("credit_max_15", vif.credit, 15);
      idle_inputs();
      vif.cancel = 1'b1;
      exp_q.push_back(mk(1'b0, 2'd0, 1'b1, 4'd15, 1'b0, 1'b0));
      cycle();
      idle_inputs();
      chk("refund_credit", vif.credit, 0);
      chk("refund_busy", vif.busy, 1);
      cycle();
      chk("refund_idle_busy", vif.busy, 0);

      // unaffordable selection, then zero-quantity selection
      coin(4'd4);
      cycle();
      idle_inputs();
      chk("insuf_credit_4", vif.credit, 4);
      stub_pos = 1'b0;
      sel(2'd2, 3'd2);
      exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1));
      cycle();
      idle_inputs();
      chk("insuf_check_busy", vif.busy, 1);
      chk("insuf_dp_count", vif.dp_count, 2);
      cycle();
      chk("insuf_back_busy", vif.busy, 0);
      chk("insuf_credit_kept", vif.credit, 4);
      sel(2'd1, 3'd0);
      exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1));
      cycle();
      idle_inputs();
      chk("count0_busy", vif.busy, 0);
      chk("count0_credit", vif.credit, 4);

      // priority: cancel beats selection beats coin, credit 7
      coin(4'd3);
      cycle();
      idle_inputs();
      chk("prio_credit_7", vif.credit, 7);
      stub_pos = 1'b1;
      vif.cancel = 1'b1;
      sel(2'd3, 3'd1);
      coin(4'd2);
      exp_q.push_back(mk(1'b0, 2'd0, 1'b1, 4'd7, 1'b1, 1'b0));
      cycle();
      idle_inputs();
      chk("prio_refund_busy", vif.busy, 1);
      chk("prio_credit_0", vif.credit, 0);
      cycle();
      chk("prio_idle_busy", vif.busy, 0);

      // reset asserted during CHECK with credit 9
      coin(4'd9);
      cycle();
      idle_inputs();
      chk("rstmid_credit_9", vif.credit, 9);
      stub_rem = 4'd5;
      sel(2'd3, 3'd1);
      cycle();
      idle_inputs();
      chk("rstmid_check_busy", vif.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", vif.busy, 0);
      chk("rstmid_credit", vif.credit, 0);
      chk("rstmid_dp_code", vif.dp_code, 0);
      chk("rstmid_dp_count", vif.dp_count, 0);
      chk("rstmid_dp_money", vif.dp_money, 0);
      chk("rstmid_dispense_code", vif.dispense_code, 0);
      chk("rstmid_change_valid", vif.change_valid, 0);
      chk("rstmid_dispense", vif.dispense, 0);
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      cycle();
      chk("rstmid_after_busy", vif.busy, 0);
      chk("rstmid_after_credit", vif.credit, 0);

      // inactivity in COLLECT
      coin(4'd6);
      cycle();
      idle_inputs();
`ifdef VEND_TIMEOUT_EN
      exp_q.push_back(mk(1'b0, 2'd0, 1'b1, 4'd6, 1'b0, 1'b0));
      repeat (12) cycle();
      chk("timeout_credit", vif.credit, 0);
`else
      repeat (1000) cycle();
      chk("no_timeout_credit", vif.credit, 6);
      chk("no_timeout_busy", vif.busy, 0);
      vif.cancel = 1'b1;
      exp_q.push_back(mk(1'b0, 2'd0, 1'b1, 4'd6, 1'b0, 1'b0));
      cycle();
      idle_inputs();
      cycle();
`endif

      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() != 0) cycle();
      end
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
